lsu_sequencer: RTL and testbench
================================

LSU_SEQUENCER -- requirements
Module: lsu_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the number of ACCESS cycles without mem_ack before bus error.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  SHALL be synchronous and active-high.
REQ-004 addr  in  32  CPU byte address (ALU result).
REQ-005 wdata  in  32  CPU store data (rs2).
REQ-006 mem_write  in  2  00 none, 01 SB, 10 SH, 11 SW.
REQ-007 mem_read  in  1  load request.
REQ-008 size_load  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-009 stall  out  1  freezes the CPU PC/regfile while high.
REQ-010 rdata  out  32  extended load result to the CPU.
REQ-011 misalign_err, bus_err  out  1 each  one-cycle error pulses.
REQ-012 mem_req, mem_we  out  1 each  memory request and write strobe.
REQ-013 mem_addr  out  32  word address, bits[1:0] SHALL be 00.
REQ-014 mem_wdata  out  32, mem_be  out  4  lane data and byte enables.
REQ-015 mem_ack  in  1, mem_rdata  in  32  memory completion and read word.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS, DONE.
REQ-017 An access is pending in IDLE when mem_write!=00 or mem_read=1; mem_write!=00 SHALL take precedence, with mem_read ignored.
REQ-018 Misaligned means: SH/LH/LHU with addr[0]=1, or SW/LW with addr[1:0]!=00; size_load 011/110/111 with mem_read SHALL also be treated as misaligned.
REQ-019 IDLE with an aligned pending access SHALL go to ACCESS next cycle and latch addr, wdata, op and size.
REQ-020 IDLE with a misaligned access SHALL go to DONE with misalign_err=1 in DONE, issue no mem_req, and leave memory unmodified.
REQ-021 stall SHALL be combinational: 1 in IDLE while an access is pending, 1 in ACCESS, 0 in DONE and in idle-without-access.
REQ-022 In ACCESS, mem_req SHALL be 1 and mem_addr/mem_we/mem_be/mem_wdata SHALL remain stable until the cycle mem_ack=1 is sampled.
REQ-023 On mem_ack in ACCESS: capture the extended mem_rdata into rdata for loads, then go to DONE; minimum latency is request cycle to DONE = 2 cycles.
REQ-024 In DONE, rdata SHALL be valid and mem_req=0; DONE SHALL go to IDLE unconditionally next cycle.
REQ-025 rdata SHALL hold its value until the next completed load; stores, errors and idle cycles SHALL leave it unchanged.
REQ-026 Store lanes: SB SHALL replicate the byte to all lanes with mem_be=0001<<addr[1:0]; SH SHALL replicate the half with mem_be=0011<<{addr[1],0}; SW SHALL use mem_be=1111; loads SHALL use mem_be=0000 and mem_we=0.
REQ-027 Load extraction: the byte or half SHALL be selected by latched addr[1:0]; LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, and LW SHALL pass the word.
REQ-028 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack; when it reaches TIMEOUT, mem_req SHALL drop next cycle and the FSM SHALL go to DONE with bus_err=1 and rdata=0 for loads.
REQ-029 mem_ack in IDLE or DONE SHALL be ignored.
REQ-030 Ack on the same cycle the counter reaches TIMEOUT SHALL be treated as success, with no bus_err.

Reset
REQ-031 Reset SHALL force state=IDLE, counter=0, rdata=0, mem_req=0, mem_we=0, mem_be=0000, mem_addr=0, mem_wdata=0, misalign_err=0, bus_err=0.
REQ-032 Reset asserted during ACCESS SHALL drop mem_req at the next edge; any later ack for the aborted access SHALL be ignored.

Verification
REQ-033 LB addr=0x103 while memory returns 0x80FF_FF00 with ack one cycle after mem_req: expect mem_addr=0x100, mem_be=0000, stall high 2 cycles, and rdata=0xFFFF_FF80 in DONE.
REQ-034 SH addr=0x0A, wdata=0x1234_ABCD: expect mem_be=1100, mem_wdata=0xABCD_ABCD, mem_we=1, and stall low in DONE.
REQ-035 LW addr=0x06: expect no mem_req, misalign_err pulse in DONE, and rdata unchanged.
REQ-036 LHU addr=0x20, ack withheld, TIMEOUT=16: expect mem_req high 16 cycles, then bus_err pulse and rdata=0.
REQ-037 Reset mid-ACCESS followed by a late ack: expect mem_req=0 after the reset edge, state IDLE, and no rdata change.
REQ-038 mem_write=11 with mem_read=1 simultaneously: expect a store only (mem_we=1, mem_be=1111).

Source files
------------

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: turns one CPU memory op into a single word-aligned bus
// request with byte lanes, stalling the core until ack, timeout or misalignment.
module lsu_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  mem_write,
  input  logic        mem_read,
  input  logic [2:0]  size_load,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       off_q;
  logic [2:0]       size_q;
  logic             load_q;
  logic             is_store, pending, misaligned, timeout_hit;
  logic [3:0]       be_nxt;
  logic [31:0]      wdata_nxt;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  size);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign is_store    = (mem_write != 2'b00);
  assign pending     = is_store | mem_read;
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Stores win over a simultaneous load; unused funct3 codes count as misaligned.
  always_comb begin
    misaligned = 1'b0;
    if (is_store) begin
      case (mem_write)
        2'b10:   misaligned = addr[0];
        2'b11:   misaligned = (addr[1:0] != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end else if (mem_read) begin
      case (size_load)
        3'b000, 3'b100: misaligned = 1'b0;
        3'b001, 3'b101: misaligned = addr[0];
        3'b010:         misaligned = (addr[1:0] != 2'b00);
        default:        misaligned = 1'b1;
      endcase
    end
  end

  always_comb begin
    be_nxt    = 4'b0000;
    wdata_nxt = 32'd0;
    case (mem_write)
      2'b01: begin
        be_nxt    = 4'b0001 << addr[1:0];
        wdata_nxt = {4{wdata[7:0]}};
      end
      2'b10: begin
        be_nxt    = 4'b0011 << {addr[1], 1'b0};
        wdata_nxt = {2{wdata[15:0]}};
      end
      2'b11: begin
        be_nxt    = 4'b1111;
        wdata_nxt = wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          stall     = 1'b1;
          state_nxt = misaligned ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (mem_ack || timeout_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: accept in IDLE; p1: wait for ack in ACCESS; results are visible in DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt     <= '0;
      rdata        <= 32'd0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_be       <= 4'b0000;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      off_q        <= 2'b00;
      size_q       <= 3'b000;
      load_q       <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (pending && !misaligned) begin
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_be    <= be_nxt;
            mem_wdata <= wdata_nxt;
            off_q     <= addr[1:0];
            size_q    <= size_load;
            load_q    <= ~is_store;
            wait_cnt  <= '0;
          end else if (pending) begin
            misalign_err <= 1'b1;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (load_q) rdata <= load_extend(mem_rdata, off_q, size_q);
          end else if (timeout_hit) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            bus_err <= 1'b1;
            if (load_q) rdata <= 32'd0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Scoreboard bench for lsu_sequencer: a byte-level reference model predicts each
// transaction; a monitor pops predictions when the sequencer releases the stall.
module tb_lsu_sequencer;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0, wdata = '0;
  logic [1:0]  mem_write = '0;
  logic        mem_read = 1'b0;
  logic [2:0]  size_load = '0;
  logic        stall, misalign_err, bus_err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  lsu_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .mem_write(mem_write),
    .mem_read(mem_read), .size_load(size_load), .stall(stall), .rdata(rdata),
    .misalign_err(misalign_err), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        berr;
    int          nreq;
    logic        we;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] wd;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0, n_fail = 0;
  logic [7:0]  refb [1024];
  logic [31:0] phys [256];
  logic [31:0] last_rdata = '0;
  int          ack_delay = 0;
  logic        force_ack = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: byte-addressed memory, alignment by access size, arithmetic extension.
  function automatic exp_t model(input logic [1:0] mw, input logic [2:0] sz,
                                 input int a, input logic [31:0] wd, input int dly);
    exp_t e;
    int nb;
    bit st, sgn, bad;
    logic [31:0] v;
    st = (mw != 2'b00); sgn = 0; bad = 0; nb = 1;
    if (st) nb = (mw == 2'b01) ? 1 : (mw == 2'b10) ? 2 : 4;
    else case (sz)
      3'd0: begin nb = 1; sgn = 1; end
      3'd1: begin nb = 2; sgn = 1; end
      3'd2: nb = 4;
      3'd4: nb = 1;
      3'd5: nb = 2;
      default: bad = 1;
    endcase
    if (a % nb != 0) bad = 1;
    e.mis = 0; e.berr = 0; e.nreq = 0; e.we = 0; e.be = 0; e.wd = 0;
    e.maddr = 32'(a) & ~32'd3;
    e.rdata = last_rdata;
    if (bad) begin
      e.mis = 1;
      return e;
    end
    e.we = st;
    if (st) begin
      e.be = 4'(((1 << nb) - 1) << (a % 4));
      e.wd = (nb == 1) ? 32'(wd[7:0]) * 32'h0101_0101 :
             (nb == 2) ? 32'(wd[15:0]) * 32'h0001_0001 : wd;
    end
    if (dly >= TIMEOUT) begin
      e.berr = 1;
      e.nreq = TIMEOUT;
      if (!st) last_rdata = 0;
    end else begin
      e.nreq = dly + 1;
      if (st) begin
        for (int i = 0; i < nb; i++) refb[a + i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < nb; i++) v = v | (32'(refb[a + i]) << (8 * i));
        if (sgn && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        last_rdata = v;
      end
    end
    e.rdata = last_rdata;
    return e;
  endfunction

  // Memory responder: acks after ack_delay request cycles, random stray acks otherwise.
  initial begin
    int rcnt;
    logic prev_req;
    rcnt = 0; prev_req = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mem_req === 1'b1) begin
        rcnt = prev_req ? rcnt + 1 : 0;
        mem_ack = (rcnt == ack_delay);
      end else begin
        rcnt = 0;
        mem_ack = force_ack || ($urandom_range(0, 3) == 0);
      end
      prev_req = (mem_req === 1'b1);
      mem_rdata = phys[mem_addr[9:2]];
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_we === 1'b1 && mem_ack === 1'b1)
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) phys[mem_addr[9:2]][8*i +: 8] = mem_wdata[8*i +: 8];
    end
  end

  // Monitor: a stall falling edge marks the DONE cycle of one transaction.
  initial begin
    logic ps, c_we;
    int nreq, nst;
    logic [31:0] c_addr, c_wd;
    logic [3:0] c_be;
    exp_t e;
    ps = 0; nreq = 0; nst = 0; c_we = 0; c_addr = 0; c_wd = 0; c_be = 0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) begin
        ps = 0; nreq = 0; nst = 0;
      end else begin
        if (mem_req === 1'b1) begin
          if (nreq == 0) begin
            c_addr = mem_addr; c_wd = mem_wdata; c_be = mem_be; c_we = mem_we;
          end else begin
            n_cmp++;
            if ({mem_addr, mem_wdata, mem_be, mem_we} !== {c_addr, c_wd, c_be, c_we}) begin
              n_fail++;
              $display("FAIL req_stable: got %h/%h/%b/%b expected %h/%h/%b/%b", mem_addr,
                       mem_wdata, mem_be, mem_we, c_addr, c_wd, c_be, c_we);
            end
          end
          nreq++;
        end
        if (stall === 1'b1) nst++;
        if (ps && stall === 1'b0) begin
          if (sbq.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_done: got completion expected none (t=%0t)", $time);
          end else begin
            e = sbq.pop_front();
            chk("rdata", rdata, e.rdata);
            chk("misalign_err", 32'(misalign_err), 32'(e.mis));
            chk("bus_err", 32'(bus_err), 32'(e.berr));
            chk("req_cycles", 32'(nreq), 32'(e.nreq));
            chk("stall_cycles", 32'(nst), 32'(e.nreq + 1));
            chk("done_req_low", 32'(mem_req), 32'd0);
            if (e.nreq > 0) begin
              chk("mem_addr", c_addr, e.maddr);
              chk("mem_be", 32'(c_be), 32'(e.be));
              chk("mem_we", 32'(c_we), 32'(e.we));
              if (e.we) chk("mem_wdata", c_wd, e.wd);
            end
          end
          nreq = 0; nst = 0;
        end else begin
          chk("no_stray_err", 32'({misalign_err, bus_err}), 32'd0);
        end
        ps = (stall === 1'b1);
      end
    end
  end

  task automatic do_op(input logic [1:0] mw, input logic mr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input int dly);
    int k;
    sbq.push_back(model(mw, sz, int'(a), wd, dly));
    ack_delay = dly;
    mem_write = mw; mem_read = mr; size_load = sz; addr = a; wdata = wd;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (stall !== 1'b0 && k < 40);
    if (k >= 40) begin
      n_cmp++; n_fail++;
      $display("FAIL op_wait: got stall stuck after %0d cycles expected release", k);
    end
    mem_write = 2'b00; mem_read = 1'b0;
  endtask

  initial begin
    int wt;
    logic [2:0] sz;
    logic [1:0] mw;
    int dly, r;
    for (int i = 0; i < 1024; i++) refb[i] = 8'($urandom);
    refb[256] = 8'h00; refb[257] = 8'hFF; refb[258] = 8'hFF; refb[259] = 8'h80;
    for (int w = 0; w < 256; w++) phys[w] = {refb[4*w+3], refb[4*w+2], refb[4*w+1], refb[4*w]};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_op(2'b00, 1'b1, 3'b000, 32'h103, 32'd0, 0);
    chk("lb_sext", rdata, 32'hFFFF_FF80);
    do_op(2'b10, 1'b0, 3'b000, 32'h0A, 32'h1234_ABCD, 1);
    chk("sh_stall_done", 32'(stall), 32'd0);
    do_op(2'b00, 1'b1, 3'b010, 32'h06, 32'd0, 0);
    chk("lw_misalign", 32'(misalign_err), 32'd1);
    do_op(2'b00, 1'b1, 3'b101, 32'h20, 32'd0, 999);
    chk("lhu_timeout_err", 32'(bus_err), 32'd1);
    chk("lhu_timeout_rdata", rdata, 32'd0);
    do_op(2'b11, 1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, 2);
    do_op(2'b00, 1'b1, 3'b010, 32'h40, 32'd0, 0);
    chk("sw_readback", rdata, 32'hDEAD_BEEF);
    do_op(2'b00, 1'b1, 3'b001, 32'h42, 32'd0, TIMEOUT - 1);
    do_op(2'b01, 1'b0, 3'b000, 32'h45, 32'h0000_0077, TIMEOUT);
    do_op(2'b00, 1'b1, 3'b110, 32'h48, 32'd0, 0);

    // Reset in the middle of an access, followed by a late ack.
    do_op(2'b00, 1'b1, 3'b010, 32'h100, 32'd0, 0);
    ack_delay = 999;
    mem_read = 1'b1; size_load = 3'b010; addr = 32'h104;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_req_high", 32'(mem_req), 32'd1);
    reset = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_req_low", 32'(mem_req), 32'd0);
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    last_rdata = 32'd0;
    force_ack = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("late_ack_req", 32'(mem_req), 32'd0);
      chk("late_ack_rdata", rdata, 32'd0);
    end
    force_ack = 1'b0;

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      dly = (r < 14) ? $urandom_range(0, 3) : (r < 16) ? TIMEOUT - 1 :
            (r == 16) ? TIMEOUT : $urandom_range(4, 8);
      mw = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      case ($urandom_range(0, 9))
        0: sz = 3'($urandom);
        1, 2: sz = 3'b000;
        3, 4: sz = 3'b001;
        5, 6: sz = 3'b010;
        7: sz = 3'b100;
        default: sz = 3'b101;
      endcase
      do_op(mw, (mw == 2'b00) ? 1'b1 : 1'($urandom), sz, 32'($urandom_range(0, 1023)),
            $urandom, dly);
      wt = $urandom_range(0, 3);
      if (wt == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end

    wt = 0;
    while (sbq.size() != 0 && wt < 50) begin @(posedge clk); #1; wt++; end
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
